// File: rtl/uart_apb_master.sv
// APB3 initiator: turns single-beat command requests into SETUP/ACCESS transfers, one response each.
// Optional ACCESS stall timeout enabled by defining UART_APB_MASTER_TIMEOUT_EN.
module uart_apb_master #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic                      i_cmd_write,
  input  logic [APB_ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [APB_DATA_WIDTH-1:0] i_cmd_wdata,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                      o_rsp_err,
  output logic [APB_ADDR_WIDTH-1:0] o_apb_paddr,
  output logic [APB_DATA_WIDTH-1:0] o_apb_pwdata,
  output logic                      o_apb_pwrite,
  output logic                      o_apb_psel,
  output logic                      o_apb_penable,
  input  logic [APB_DATA_WIDTH-1:0] i_apb_prdata,
  input  logic                      i_apb_pready,
  input  logic                      i_apb_pslverr,
  output logic                      o_busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state;
  logic   timeout_hit;

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // Handshakes: a beat transfers on a rising edge where valid and ready are both high;
  // a raised valid holds its payload until that edge. o_cmd_ready depends only on state.
  assign o_cmd_ready = (state == IDLE);
  assign o_busy      = ~o_cmd_ready;

`ifdef UART_APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !i_apb_pready) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // This PREADY-low edge would bring the count to TIMEOUT_CYCLES.
  assign timeout_hit = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      o_apb_paddr   <= '0;
      o_apb_pwdata  <= '0;
      o_apb_pwrite  <= 1'b0;
      o_apb_psel    <= 1'b0;
      o_apb_penable <= 1'b0;
      o_rsp_valid   <= 1'b0;
      o_rsp_rdata   <= '0;
      o_rsp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            o_apb_paddr  <= i_cmd_addr;
            o_apb_pwdata <= i_cmd_wdata;
            o_apb_pwrite <= i_cmd_write;
            o_apb_psel   <= 1'b1;
            state        <= SETUP;
          end
        end
        SETUP: begin
          o_apb_penable <= 1'b1;
          state         <= ACCESS;
        end
        ACCESS: begin
          // Normal completion takes priority over a timeout on the same edge.
          if (i_apb_pready) begin
            o_rsp_rdata   <= o_apb_pwrite ? '0 : i_apb_prdata;
            o_rsp_err     <= i_apb_pslverr;
            o_apb_psel    <= 1'b0;
            o_apb_penable <= 1'b0;
            o_rsp_valid   <= 1'b1;
            state         <= RESP;
          end else if (timeout_hit) begin
            o_rsp_rdata   <= '0;
            o_rsp_err     <= 1'b1;
            o_apb_psel    <= 1'b0;
            o_apb_penable <= 1'b0;
            o_rsp_valid   <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_apb_master.sv
// Bench for uart_apb_master: table vectors, randomized transfers against a transfer-level model,
// and hand-written sequences for reset, timeout/stall and back-to-back traffic.
module tb_uart_apb_master;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pwrite, psel, penable, pready, pslverr, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [DW:0] exp_q[$];

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic [DW-1:0] prdata;
    logic          slverr;
    int            hold;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  uart_apb_master #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_apb_paddr(paddr), .o_apb_pwdata(pwdata), .o_apb_pwrite(pwrite),
    .o_apb_psel(psel), .o_apb_penable(penable),
    .i_apb_prdata(prdata), .i_apb_pready(pready), .i_apb_pslverr(pslverr),
    .o_busy(busy)
  );

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard
  task automatic sb_push(input logic err, input logic [DW-1:0] rdata);
    exp_q.push_back({err, rdata});
  endtask

  task automatic sb_check(input string name);
    logic [DW:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got response expected none queued", name);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_err"}, 64'(rsp_err), 64'(e[DW]));
      chk({name, "_rdata"}, 64'(rsp_rdata), 64'(e[DW-1:0]));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_paddr"}, 64'(paddr), 0);
    chk({tag, "_pwdata"}, 64'(pwdata), 0);
    chk({tag, "_pwrite"}, 64'(pwrite), 0);
    chk({tag, "_psel"}, 64'(psel), 0);
    chk({tag, "_penable"}, 64'(penable), 0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
    chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 0);
    chk({tag, "_rsp_err"}, 64'(rsp_err), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 1);
  endtask

  // One complete transfer acting as both command source and APB completer.
  task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int waits, input logic [DW-1:0] pdata, input logic slverr,
                         input int hold, input logic [DW-1:0] exp_rdata, input logic exp_err);
    chk("idle_ready", 64'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    sb_push(exp_err, exp_rdata);
    step();
    chk("setup_psel", 64'(psel), 1);
    chk("setup_penable", 64'(penable), 0);
    chk("setup_paddr", 64'(paddr), 64'(addr));
    chk("setup_pwrite", 64'(pwrite), 64'(wr));
    chk("setup_pwdata", 64'(pwdata), 64'(wdata));
    chk("setup_busy", 64'(busy), 1);
    // Unrelated command held during the transfer must be ignored.
    cmd_write = ~wr;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    pready    = 1'($urandom_range(0, 1));
    prdata    = $urandom;
    step();
    for (int i = 0; i <= waits; i++) begin
      chk("access_psel", 64'(psel), 1);
      chk("access_penable", 64'(penable), 1);
      chk("access_paddr", 64'(paddr), 64'(addr));
      chk("access_pwdata", 64'(pwdata), 64'(wdata));
      chk("access_pwrite", 64'(pwrite), 64'(wr));
      pready  = (i == waits);
      prdata  = (i == waits) ? pdata : $urandom;
      pslverr = (i == waits) ? slverr : 1'($urandom_range(0, 1));
      step();
    end
    pready  = 1'b0;
    prdata  = $urandom;
    pslverr = 1'($urandom_range(0, 1));
    chk("resp_valid", 64'(rsp_valid), 1);
    chk("resp_psel", 64'(psel), 0);
    chk("resp_penable", 64'(penable), 0);
    chk("resp_cmd_ready", 64'(cmd_ready), 0);
    sb_check("resp");
    rsp_ready = (hold == 0);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", 64'(rsp_valid), 1);
      chk("hold_cmd_ready", 64'(cmd_ready), 0);
      chk("hold_psel", 64'(psel), 0);
      chk("hold_rdata", 64'(rsp_rdata), 64'(exp_rdata));
      chk("hold_err", 64'(rsp_err), 64'(exp_err));
      rsp_ready = (h == hold - 1);
    end
    step();
    chk("done_valid", 64'(rsp_valid), 0);
    chk("done_ready", 64'(cmd_ready), 1);
    chk("done_psel", 64'(psel), 0);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    logic          wr, se;
    logic [DW-1:0] pd;
    int            issued, got, last;
    logic          b2b_wr[8];
    logic [DW-1:0] b2b_pd[8];

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    step();
    step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 0, 32'hFFFF_FFFF, 1'b0, 0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0004, 32'h0, 3, 32'h0000_00C3, 1'b0, 1, 32'h0000_00C3, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0008, 32'h0, 0, 32'h1234_5678, 1'b1, 5, 32'h1234_5678, 1'b1};
    vecs[3] = '{1'b1, 32'h0000_000C, 32'h0BAD_F00D, 2, 32'h0000_5555, 1'b1, 2, 32'h0, 1'b1};
    vecs[4] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 1, 32'hFFFF_FFFF, 1'b0, 0, 32'hFFFF_FFFF, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_0000, 32'h0, 0, 32'h0000_0077, 1'b0, 3, 32'h0, 1'b0};
    for (int v = 0; v < 6; v++)
      run_txn(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].waits, vecs[v].prdata,
              vecs[v].slverr, vecs[v].hold, vecs[v].exp_rdata, vecs[v].exp_err);

    // Randomized transfers: a write answers 0, a read answers PRDATA; err mirrors PSLVERR.
    for (int r = 0; r < 20; r++) begin
      wr = 1'($urandom_range(0, 1));
      pd = $urandom;
      se = 1'($urandom_range(0, 1));
      run_txn(wr, $urandom, $urandom, $urandom_range(0, 5), pd, se, $urandom_range(0, 3),
              wr ? '0 : pd, se);
    end

    // Stall with PREADY held low.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8; cmd_wdata = 32'h0;
`ifdef UART_APB_MASTER_TIMEOUT_EN
    sb_push(1'b1, '0);
`else
    sb_push(1'b0, 32'h0000_005A);
`endif
    step();
    cmd_valid = 1'b0; pready = 1'b0; prdata = 32'hDEAD_BEEF; pslverr = 1'b0;
    step();
`ifdef UART_APB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      chk("to_access", 64'(psel & penable), 1);
      step();
    end
`else
    for (int i = 0; i < 110; i++) begin
      chk("stall_psel", 64'(psel & penable), 1);
      step();
    end
    pready = 1'b1; prdata = 32'h0000_005A;
    step();
    pready = 1'b0;
`endif
    chk("stall_rsp_valid", 64'(rsp_valid), 1);
    chk("stall_psel_low", 64'(psel | penable), 0);
    sb_check("stall");
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("stall_done", 64'(cmd_ready), 1);

    // Reset during ACCESS of a write abandons it without a response.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h1357_9BDF;
    step();
    cmd_valid = 1'b0;
    step();
    chk("pre_rst_penable", 64'(penable), 1);
    rst = 1'b1;
    step();
    chk_reset_outputs("mid_rst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_no_rsp", 64'(rsp_valid), 0);
    end
    run_txn(1'b0, 32'h24, 32'h0, 1, 32'h0000_0099, 1'b0, 0, 32'h0000_0099, 1'b0);

    // Back-to-back: command valid and response ready held high.
    rsp_ready = 1'b1; pready = 1'b1; pslverr = 1'b0;
    issued = 0; got = 0; last = 0;
    for (int k = 0; k < 8; k++) begin
      b2b_wr[k] = (k % 2 == 0);
      b2b_pd[k] = $urandom;
    end
    for (int c = 0; c < 50 && got < 8; c++) begin
      if (rsp_valid) begin
        sb_check("b2b");
        if (got > 0) chk("b2b_spacing", 64'(cyc - last), 4);
        last = cyc;
        got++;
      end
      if (cmd_ready) begin
        if (issued < 8) begin
          cmd_valid = 1'b1;
          cmd_write = b2b_wr[issued];
          cmd_addr  = 32'h100 + 32'(4 * issued);
          cmd_wdata = $urandom;
          prdata    = b2b_pd[issued];
          sb_push(1'b0, b2b_wr[issued] ? '0 : b2b_pd[issued]);
          issued++;
        end else begin
          cmd_valid = 1'b0;
        end
      end
      step();
    end
    chk("b2b_count", 64'(got), 8);
    chk("sb_drained", 64'(exp_q.size()), 0);
    cmd_valid = 1'b0; rsp_ready = 1'b0; pready = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
